// File: rtl/hash_tx_serializer.sv
// hash_tx_serializer: captures a digest on the rising edge of hash_valid_i and
// streams it MSB-first to a UART TX over a valid/ready byte handshake, either
// as raw bytes or as lowercase ASCII hex, with an optional CR LF trailer.
module hash_tx_serializer #(
  parameter int unsigned HASH_W    = 512,
  parameter int unsigned HEX_MODE  = 1,
  parameter int unsigned APPEND_NL = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [HASH_W-1:0] hash_i,
  input  logic              hash_valid_i,
  output logic [7:0]        tx_data_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  output logic              busy_o,
  output logic              done_o
);

  localparam int unsigned N_DIG  = (HEX_MODE != 0) ? HASH_W / 4 : HASH_W / 8;
  localparam int unsigned N_TRL  = (APPEND_NL != 0) ? 2 : 0;
  localparam int unsigned N_CHAR = N_DIG + N_TRL;
  localparam int unsigned CNT_W  = $clog2(N_CHAR + 1);
  localparam int unsigned STEP   = (HEX_MODE != 0) ? 4 : 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [HASH_W-1:0]  r_shift;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_hv_q;

  logic               w_trig;
  logic               w_hs;
  logic               w_last;
  logic [HASH_W-1:0]  w_shift_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [7:0]         w_char_nxt;

  // Character presented for the top of a digest word (hex nibble or raw byte)
  function automatic logic [7:0] f_enc(input logic [HASH_W-1:0] v);
    logic [3:0] nib;
    nib = v[HASH_W-1 -: 4];
    if (HEX_MODE != 0) begin
      f_enc = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h57 + {4'h0, nib});
    end else begin
      f_enc = v[HASH_W-1 -: 8];
    end
  endfunction

  assign w_trig      = hash_valid_i & ~r_hv_q;
  assign w_hs        = tx_valid_o & tx_ready_i;
  assign w_last      = (r_cnt == CNT_W'(N_CHAR - 1));
  assign w_shift_nxt = r_shift << STEP;
  assign w_cnt_nxt   = r_cnt + CNT_W'(1);

  // Next character after a handshake: digest data, then the CR LF trailer
  always_comb begin
    w_char_nxt = f_enc(w_shift_nxt);
    if (N_TRL != 0 && w_cnt_nxt == CNT_W'(N_DIG)) begin
      w_char_nxt = 8'h0D;
    end else if (N_TRL != 0 && w_cnt_nxt == CNT_W'(N_DIG + 1)) begin
      w_char_nxt = 8'h0A;
    end
  end

  // Previous hash_valid_i level, updated every cycle for edge detection
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_hv_q <= 1'b0;
    end else begin
      r_hv_q <= hash_valid_i;
    end
  end

  // Capture / send / done sequencer with registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_cnt      <= '0;
      tx_data_o  <= 8'h00;
      tx_valid_o <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_trig) begin
            r_shift    <= hash_i;
            r_cnt      <= '0;
            tx_data_o  <= f_enc(hash_i);
            tx_valid_o <= 1'b1;
            busy_o     <= 1'b1;
            r_state    <= S_SEND;
          end
        end
        S_SEND: begin
          if (w_hs) begin
            r_cnt <= w_cnt_nxt;
            if (w_last) begin
              tx_valid_o <= 1'b0;
              tx_data_o  <= 8'h00;
              busy_o     <= 1'b0;
              done_o     <= 1'b1;
              r_state    <= S_DONE;
            end else begin
              r_shift   <= w_shift_nxt;
              tx_data_o <= w_char_nxt;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/hash_tx_serializer.md
Name: hash_tx_serializer

Overview:
- Downstream consumer of the SHA3-512 driver.
- Captures the 512-bit digest when the driver's output-valid level rises.
- Streams the digest as bytes, most significant byte first, to the UART transmitter over a valid/ready byte handshake.
- In HEX_MODE each byte goes out as two lowercase ASCII hex characters; a CR LF trailer is optional.

Parameters:
HASH_W, 512, digest width in bits; must be a multiple of 8
HEX_MODE, 1, 1 = ASCII hex (two chars per byte, high nibble first); 0 = raw bytes
APPEND_NL, 1, 1 = send 0x0D then 0x0A after the digest; 0 = no trailer

Ports:
clk_i  input  1  system clock, rising edge
rst_ni  input  1  asynchronous reset, active low
hash_i  input  HASH_W  digest from SHA driver; sampled only on the capture cycle
hash_valid_i  input  1  digest-valid level from SHA driver (held high once set)
tx_data_o  output  8  byte/character to UART TX
tx_valid_o  output  1  tx_data_o is valid
tx_ready_i  input  1  UART TX accepts the byte this cycle
busy_o  output  1  high from the capture cycle until the last character is accepted
done_o  output  1  one-cycle pulse after the last character is accepted

Behaviour:
- Reset: one clock, asynchronous active-low reset; all flops clear on rst_ni low without waiting for a clock edge.
  - Reset values: tx_data_o=0, tx_valid_o=0, busy_o=0, done_o=0, state=IDLE, char counter=0, hash_valid_i edge register=0.
- Trigger: capture is on the rising edge of hash_valid_i, i.e. hash_valid_i=1 while the registered previous value is 0.
  - The edge register updates every cycle in every state.
  - A level held high never retriggers.
- State IDLE:
  - On a trigger edge: load hash_i into the shift register, clear the char counter, set busy_o, go to SEND.
- State SEND:
  - tx_valid_o=1; tx_data_o is the current character.
  - tx_data_o is held stable while tx_valid_o=1 and tx_ready_i=0.
  - Handshake = tx_valid_o & tx_ready_i. On handshake the counter increments, and the shift register shifts by 8 (raw) or by 4 on each character (hex).
  - When the handshake is on the last character: go to DONE.
- State DONE:
  - Single cycle: tx_valid_o=0, busy_o=0, done_o=1, then return to IDLE.
- Latency: first character is presented on tx_data_o with tx_valid_o=1 in the cycle after the capture edge.
  - With tx_ready_i held high, one character is sent per cycle.
- Character count:
  - Raw mode: HASH_W/8 characters (64).
  - Hex mode: HASH_W/4 characters (128).
  - APPEND_NL adds 2 (hex default = 130).
  - Counter is 8 bits at the defaults; width is clog2(max count + 1).
- Hex encoding: nibble 0–9 → 0x30–0x39; nibble 10–15 → 0x61–0x66 (lowercase).
  - Nibble order: hash_i[HASH_W-1:HASH_W-4] is sent first.
- Trailer: 0x0D, then 0x0A, sent after the last digest character, under the same handshake.
- Trigger edge while busy_o=1 (SEND/DONE): ignored; the edge register still updates, so that edge is lost.
  - A new digest requires hash_valid_i to fall and rise again after the block returns to IDLE.
- Simultaneous events: tx_ready_i high while tx_valid_o=0 has no effect.
- hash_i changes after capture: no effect on the stream in progress.
- Reset mid-stream: tx_valid_o drops asynchronously. No done_o pulse. After release the block is in IDLE and the edge register is 0.
  - Consequence: if hash_valid_i is still high at release, the next cycle sees a rising edge and the block recaptures.

Test Plan:
1. Hex, trailer, no backpressure:
   - Stimulus: hash_i = 512'h0123456789abcdef repeated 8 times; hash_valid_i rises; tx_ready_i=1.
   - Required: 130 consecutive handshakes; chars "0123456789abcdef"×8 (0x30,0x31,…,0x66), then 0x0D, 0x0A; done_o pulses once, 131 cycles after capture.
2. Backpressure:
   - Stimulus: same digest; tx_ready_i toggles 1-0-0-1 randomly.
   - Required: tx_data_o is stable whenever valid&!ready; byte sequence is identical to test 1; no drops or duplicates.
3. Level hold:
   - Stimulus: hash_valid_i stays high for 1000 cycles after a stream completes.
   - Required: exactly one stream; busy_o stays 0 after done_o.
   - Continuation: drop hash_valid_i, raise it again with hash_i = all 0xFF → a second stream of 128 × 0x66 plus CR LF.
4. Raw mode (HEX_MODE=0, APPEND_NL=0):
   - Stimulus: hash_i[511:504]=0xA5, hash_i[7:0]=0x3C, rest 0.
   - Required: 64 bytes; first byte 0xA5, last byte 0x3C, 62 bytes of 0x00 between.
5. Retrigger while busy:
   - Stimulus: pulse hash_valid_i low/high during character 40 of a stream.
   - Required: stream completes unchanged (130 chars); no second stream.
6. Reset mid-stream:
   - Stimulus: assert rst_ni low during character 20, asynchronous to clk_i.
   - Required: tx_valid_o/busy_o go to 0 before the next clock edge; no done_o pulse.
   - Continuation: after release with hash_valid_i high, a fresh full 130-char stream starts from character 0.
